fpdiv_seq: RTL
==============

Name: fpdiv_seq

Overview:
- Control sequencer for the iterative Goldschmidt float32 divider datapath.
- Accepts one operand pair per operation over a valid/ready handshake, registers it, and drives the load, stage and round controls of the datapath.
- Resolves IEEE special operands without iterating, holds the result until the consumer takes it, and sits between the operand source and the fpdiv core.

Parameters:
- ITERS, 3, Goldschmidt iterations per operation; each iteration is one N stage then one D stage, so 2*ITERS stage cycles.
- CW, 3, stage-counter width; must satisfy 2^CW >= 2*ITERS.

Ports:
- clk  in  1  clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept an operand pair.
- dividend  in  32  float32 N.
- divisor  in  32  float32 D.
- op_a  out  32  registered dividend to the datapath.
- op_b  out  32  registered divisor to the datapath.
- dp_load  out  1  datapath loads op_a/op_b and the reciprocal seed.
- dp_stage  out  1  0 = N-multiply stage, 1 = D-multiply stage.
- dp_first  out  1  first iteration; datapath uses the seed instead of the complement of D.
- dp_round  out  1  datapath rounds and packs the quotient.
- mode  out  1  busy; high from LOAD through ROUND.
- dp_result  in  32  packed quotient from the datapath, valid in the ROUND cycle.
- quotient  out  32  registered result.
- out_valid  out  1  quotient valid.
- out_ready  in  1  consumer accepts quotient.

Behaviour:
- Reset values: all outputs 0, except in_ready = 1 (IDLE). Operand and quotient registers clear to 0. State is IDLE and the stage counter is 0.
- States: IDLE, LOAD, ITER, ROUND, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid, capture dividend/divisor into op_a/op_b and go to LOAD.
- LOAD:
  - dp_load = 1, mode = 1, in_ready = 0.
  - Classify the operands. If special, go to DONE and latch the special quotient. Otherwise go to ITER with counter = 0.
- ITER:
  - mode = 1. dp_stage = counter[0]. dp_first = 1 only when counter is 0 or 1.
  - Counter increments each cycle. When counter = 2*ITERS-1, go to ROUND.
- ROUND:
  - mode = 1, dp_round = 1.
  - Latch dp_result into quotient and go to DONE.
- DONE:
  - out_valid = 1; quotient is held stable.
  - On out_ready, go to IDLE. The next in_valid is accepted one cycle later; there is no accept in the DONE cycle.
- Latency, acceptance edge to out_valid:
  - Normal operands: 2*ITERS+3 cycles (ITERS=3: 9 cycles).
  - Special operands: 2 cycles.
- mode falls exactly once per operation, on entry to DONE. Checkers sample results on this edge.
- Special classification; result sign s = sign(N) xor sign(D):
  - Any NaN operand -> 7fc00000.
  - 0/0 or inf/inf -> 7fc00000.
  - Finite nonzero / 0 -> {s, 7f800000[30:0]}.
  - Inf / finite -> {s, 7f800000[30:0]}.
  - 0 / nonzero, or finite / inf -> {s, 31'b0}.
  - Subnormals are not special; they iterate.
- While not IDLE, in_valid is ignored and in_ready = 0, so operands never change mid-operation.
- Asynchronous reset in any state returns to IDLE immediately. out_valid drops and the in-flight result is discarded.
- If out_ready is high in the same cycle DONE is entered, the result is consumed that cycle.

Optional Feature:
- Macro: FPDIV_SEQ_PERF_EN.
- Enabled: adds outputs perf_ops[31:0] and perf_special[31:0], both cleared by reset.
  - perf_ops counts completed operations, incremented on out_valid & out_ready.
  - perf_special counts those that took the special path.
  - Both counters wrap modulo 2^32.
- Disabled: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- 3f800000 / 40000000, ITERS=3, dp_result stubbed to 3f000000, out_ready = 1:
  - dp_load for 1 cycle, then 6 ITER cycles with dp_stage 0,1,0,1,0,1 and dp_first high on the first two.
  - dp_round for 1 cycle, out_valid 9 cycles after accept, quotient = 3f000000.
- 3f800000 / 00000000 -> quotient 7f800000 two cycles after accept; dp_round never asserted.
- 80000000 / 00000000 -> 7fc00000.
- c0000000 / 7f800000 -> 80000000.
- 7fc00001 / 3f800000 -> 7fc00000.
- out_ready held low for 5 cycles in DONE -> out_valid and quotient stable; in_ready = 0; a new in_valid is ignored until one cycle after the handshake.
- reset_n pulsed low in the third ITER cycle -> all outputs 0 and in_ready = 1 immediately; the next operation has normal latency and the correct result.
- Four back-to-back operations with out_ready = 1 -> one mode falling edge per operation, each 10 cycles apart; the perf_ops = 4 check applies only in the FPDIV_SEQ_PERF_EN build.

Source files
------------

// File: rtl/fpdiv_seq.sv
// rtl/fpdiv_seq.sv - Goldschmidt float32 divider control sequencer (optional counters: FPDIV_SEQ_PERF_EN)
module fpdiv_seq #(
    parameter int ITERS = 3,
    parameter int CW    = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        dp_load,
    output logic        dp_stage,
    output logic        dp_first,
    output logic        dp_round,
    output logic        mode,
    input  logic [31:0] dp_result,
    output logic [31:0] quotient,
    output logic        out_valid,
    input  logic        out_ready
`ifdef FPDIV_SEQ_PERF_EN
    ,
    output logic [31:0] perf_ops,
    output logic [31:0] perf_special
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_ROUND,
        S_DONE
    } state_t;

    localparam logic [CW-1:0] LAST_STAGE = CW'(2 * ITERS - 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;

    logic        a_exp_max;
    logic        b_exp_max;
    logic        a_nan;
    logic        b_nan;
    logic        a_inf;
    logic        b_inf;
    logic        a_zero;
    logic        b_zero;
    logic        q_sign;
    logic        is_special;
    logic [31:0] special_q;

    assign a_exp_max = &op_a[30:23];
    assign b_exp_max = &op_b[30:23];
    assign a_nan     = a_exp_max & (|op_a[22:0]);
    assign b_nan     = b_exp_max & (|op_b[22:0]);
    assign a_inf     = a_exp_max & ~(|op_a[22:0]);
    assign b_inf     = b_exp_max & ~(|op_b[22:0]);
    assign a_zero    = ~(|op_a[30:0]);
    assign b_zero    = ~(|op_b[30:0]);
    assign q_sign    = op_a[31] ^ op_b[31];

    // Classify the registered operands; the checks are ordered so each later rule only sees cases the earlier ones left over
    always_comb begin
        is_special = 1'b1;
        special_q  = 32'h0000_0000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            special_q = 32'h7fc0_0000;
        end else if (b_zero || a_inf) begin
            special_q = {q_sign, 8'hff, 23'h0};
        end else if (a_zero || b_inf) begin
            special_q = {q_sign, 31'h0};
        end else begin
            is_special = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and Moore control outputs
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        dp_load   = 1'b0;
        dp_stage  = 1'b0;
        dp_first  = 1'b0;
        dp_round  = 1'b0;
        mode      = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                dp_load  = 1'b1;
                mode     = 1'b1;
                state_nx = is_special ? S_DONE : S_ITER;
            end
            S_ITER: begin
                mode     = 1'b1;
                dp_stage = cnt[0];
                dp_first = (cnt < CW'(2));
                if (cnt == LAST_STAGE) begin
                    state_nx = S_ROUND;
                end
            end
            S_ROUND: begin
                mode     = 1'b1;
                dp_round = 1'b1;
                state_nx = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Stage counter: cleared while loading, advanced once per N or D stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state == S_LOAD) begin
            cnt <= '0;
        end else if (state == S_ITER) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Operand capture only on the IDLE handshake, so operands are frozen for the whole operation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_a <= 32'h0;
            op_b <= 32'h0;
        end else if (state == S_IDLE && in_valid) begin
            op_a <= dividend;
            op_b <= divisor;
        end
    end

    // Result register: special quotient straight from LOAD, otherwise the datapath result in ROUND
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            quotient <= 32'h0;
        end else if (state == S_LOAD && is_special) begin
            quotient <= special_q;
        end else if (state == S_ROUND) begin
            quotient <= dp_result;
        end
    end

`ifdef FPDIV_SEQ_PERF_EN
    logic spec_path;

    // Remember which path the current operation took so it can be counted at completion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spec_path <= 1'b0;
        end else if (state == S_LOAD) begin
            spec_path <= is_special;
        end
    end

    // Completion counters, bumped on the result handshake and wrapping naturally
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_ops     <= 32'h0;
            perf_special <= 32'h0;
        end else if (out_valid && out_ready) begin
            perf_ops <= perf_ops + 32'd1;
            if (spec_path) begin
                perf_special <= perf_special + 32'd1;
            end
        end
    end
`endif

endmodule
